// File: rtl/seg7_pkg.sv
// Shared definitions for the 7-segment scan driver: segment patterns
// (active-high, {g,f,e,d,c,b,a}), FSM state type and anode select codes.
package seg7_pkg;

  localparam logic [6:0] SEG_0    = 7'h3F;
  localparam logic [6:0] SEG_1    = 7'h06;
  localparam logic [6:0] SEG_2    = 7'h5B;
  localparam logic [6:0] SEG_3    = 7'h4F;
  localparam logic [6:0] SEG_4    = 7'h66;
  localparam logic [6:0] SEG_5    = 7'h6D;
  localparam logic [6:0] SEG_6    = 7'h7D;
  localparam logic [6:0] SEG_7    = 7'h07;
  localparam logic [6:0] SEG_8    = 7'h7F;
  localparam logic [6:0] SEG_9    = 7'h6F;
  localparam logic [6:0] SEG_DASH = 7'h40;

  localparam logic [3:0] AN_ONES = 4'b0001;
  localparam logic [3:0] AN_TENS = 4'b0010;

  typedef enum logic {
    BLANK = 1'b0,
    SHOW  = 1'b1
  } state_e;

  // True when exactly one anode bit is set; anything else is displayed as off.
  function automatic logic is_onehot4(input logic [3:0] v);
    return (v == 4'b0001) || (v == 4'b0010) || (v == 4'b0100) || (v == 4'b1000);
  endfunction

endpackage

// File: rtl/seg7_decode.sv
// Combinational BCD to active-high 7-segment decoder; codes 10..15 show a dash.
module seg7_decode
  import seg7_pkg::*;
(
  input  logic [3:0] bcd_i,
  output logic [6:0] seg_o
);

  // Lookup of the segment pattern for one digit.
  always_comb begin
    seg_o = SEG_DASH;
    case (bcd_i)
      4'd0:    seg_o = SEG_0;
      4'd1:    seg_o = SEG_1;
      4'd2:    seg_o = SEG_2;
      4'd3:    seg_o = SEG_3;
      4'd4:    seg_o = SEG_4;
      4'd5:    seg_o = SEG_5;
      4'd6:    seg_o = SEG_6;
      4'd7:    seg_o = SEG_7;
      4'd8:    seg_o = SEG_8;
      4'd9:    seg_o = SEG_9;
      default: seg_o = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/seg7_scan_driver.sv
// Display-side stage: registers the multiplexed digit/anode stream, inserts an
// all-off dead time on every anode change, decodes, blanks a leading zero on
// the tens digit and drives the pins with the configured polarity.
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int unsigned BLANK_CYCLES   = 4,
  parameter bit          LZB            = 1'b1,
  parameter bit          SEG_ACTIVE_LOW = 1'b1,
  parameter bit          AN_ACTIVE_LOW  = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] bcd,
  input  logic [3:0] c,
  output logic [6:0] seg,
  output logic [3:0] an
);

  localparam logic [7:0] CNT_RELOAD = 8'(BLANK_CYCLES - 1);

  logic [3:0] bcd_q, c_q;
  logic [3:0] dig_lat_q, dig_lat_d;
  logic [3:0] an_lat_q, an_lat_d;
  state_e     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic [6:0] seg_ah_q, seg_ah_d;
  logic [3:0] an_ah_q, an_ah_d;
  logic [6:0] seg_dec;

  // Input stage: capture the splitter outputs every cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      bcd_q <= 4'd0;
      c_q   <= 4'd0;
    end else begin
      bcd_q <= bcd;
      c_q   <= c;
    end
  end

  // State, latch and counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= BLANK;
      cnt_q     <= CNT_RELOAD;
      dig_lat_q <= 4'd0;
      an_lat_q  <= 4'd0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      dig_lat_q <= dig_lat_d;
      an_lat_q  <= an_lat_d;
    end
  end

  // Next-state logic: an anode change always (re)starts the dead time, even
  // when the counter is expiring in the same cycle.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    dig_lat_d = dig_lat_q;
    an_lat_d  = an_lat_q;
    if (c_q != an_lat_q) begin
      dig_lat_d = bcd_q;
      an_lat_d  = c_q;
      cnt_d     = CNT_RELOAD;
      state_d   = BLANK;
    end else begin
      case (state_q)
        BLANK: begin
          if (cnt_q == 8'd0) begin
            state_d = SHOW;
          end else begin
            cnt_d = cnt_q - 8'd1;
          end
        end
        SHOW: begin
          if (bcd_q != dig_lat_q) begin
            dig_lat_d = bcd_q;
          end
        end
        default: state_d = BLANK;
      endcase
    end
  end

  seg7_decode u_decode (
    .bcd_i (dig_lat_d),
    .seg_o (seg_dec)
  );

  // Output selection from the next-state values so the pins follow the
  // state change on the same edge (anode change -> off one edge later).
  always_comb begin
    seg_ah_d = 7'd0;
    an_ah_d  = 4'd0;
    if ((state_d == SHOW) && is_onehot4(an_lat_d) &&
        !(LZB && (an_lat_d == AN_TENS) && (dig_lat_d == 4'd0))) begin
      seg_ah_d = seg_dec;
      an_ah_d  = an_lat_d;
    end
  end

  // Registered active-high pin values; reset forces everything off.
  always_ff @(posedge clk) begin
    if (rst) begin
      seg_ah_q <= 7'd0;
      an_ah_q  <= 4'd0;
    end else begin
      seg_ah_q <= seg_ah_d;
      an_ah_q  <= an_ah_d;
    end
  end

  // Polarity is applied last, on the registered values.
  assign seg = SEG_ACTIVE_LOW ? ~seg_ah_q : seg_ah_q;
  assign an  = AN_ACTIVE_LOW  ? ~an_ah_q  : an_ah_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Scoreboard bench: each stimulus cycle pushes the expected pin values seen
// after the upcoming edge; a monitor pops and compares one entry per cycle.
// Two instances share the inputs: LZB=1 (dut0) and LZB=0 (dut1).
module tb_seg7_scan_driver;

  typedef struct {
    logic [6:0] seg;
    logic [3:0] an;
    string      name;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] bcd = 4'd0;
  logic [3:0] c   = 4'd0;
  logic [6:0] seg0, seg1;
  logic [3:0] an0, an1;

  exp_t q0[$];
  exp_t q1[$];
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  seg7_scan_driver #(.BLANK_CYCLES(4), .LZB(1'b1), .SEG_ACTIVE_LOW(1'b1), .AN_ACTIVE_LOW(1'b1)) dut0 (
    .clk (clk), .rst (rst), .bcd (bcd), .c (c), .seg (seg0), .an (an0)
  );

  seg7_scan_driver #(.BLANK_CYCLES(4), .LZB(1'b0), .SEG_ACTIVE_LOW(1'b1), .AN_ACTIVE_LOW(1'b1)) dut1 (
    .clk (clk), .rst (rst), .bcd (bcd), .c (c), .seg (seg1), .an (an1)
  );

  // Pin-level (active-low) constants.
  localparam logic [6:0] OFF_S = 7'h7F;
  localparam logic [3:0] OFF_A = 4'hF;
  localparam logic [3:0] A1    = 4'hE;
  localparam logic [3:0] A10   = 4'hD;

  // Drive n cycles of one input vector, with separate expectations per DUT.
  task automatic run2(input int n, input logic r, input logic [3:0] b, input logic [3:0] cc,
                      input logic [6:0] s0, input logic [3:0] a0,
                      input logic [6:0] s1, input logic [3:0] a1, input string name);
    exp_t e;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      rst = r;
      bcd = b;
      c   = cc;
      e.seg = s0; e.an = a0; e.name = name;
      q0.push_back(e);
      e.seg = s1; e.an = a1;
      q1.push_back(e);
    end
  endtask

  task automatic run(input int n, input logic r, input logic [3:0] b, input logic [3:0] cc,
                     input logic [6:0] s, input logic [3:0] a, input string name);
    run2(n, r, b, cc, s, a, s, a, name);
  endtask

  // Monitor: one comparison per DUT for every queued cycle.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q0.size() > 0) begin
        e = q0.pop_front();
        n_cmp++;
        if (seg0 !== e.seg || an0 !== e.an) begin
          n_err++;
          $display("FAIL %s dut0: seg=%h an=%h expected seg=%h an=%h", e.name, seg0, an0, e.seg, e.an);
        end
      end
      if (q1.size() > 0) begin
        e = q1.pop_front();
        n_cmp++;
        if (seg1 !== e.seg || an1 !== e.an) begin
          n_err++;
          $display("FAIL %s dut1: seg=%h an=%h expected seg=%h an=%h", e.name, seg1, an1, e.seg, e.an);
        end
      end
    end
  end

  initial begin
    // Reset, then hold bcd=5/ones: capture at edge 1, detect at edge 2,
    // blank through edge 5, digit shown from edge 6.
    run(2, 1'b1, 4'd5, 4'b0001, OFF_S, OFF_A, "reset");
    run(5, 1'b0, 4'd5, 4'b0001, OFF_S, OFF_A, "post_reset_blank");
    run(1, 1'b0, 4'd5, 4'b0001, 7'h12, A1, "show_5");

    // Digit-only change 5 -> 3, visible one edge after capture.
    run(1, 1'b0, 4'd3, 4'b0001, 7'h12, A1, "dig_chg_old");
    run(1, 1'b0, 4'd3, 4'b0001, 7'h30, A1, "show_3");

    // Anode change to tens/1: four blank cycles, then display.
    run(1, 1'b0, 4'd1, 4'b0010, 7'h30, A1, "an_chg_capture");
    run(4, 1'b0, 4'd1, 4'b0010, OFF_S, OFF_A, "an_chg_blank");
    run(1, 1'b0, 4'd1, 4'b0010, 7'h79, A10, "show_tens_1");

    // Tens digit 0: blanked with LZB=1, shown with LZB=0.
    run(1, 1'b0, 4'd0, 4'b0010, 7'h79, A10, "tens0_capture");
    run2(2, 1'b0, 4'd0, 4'b0010, OFF_S, OFF_A, 7'h40, A10, "tens0_lzb");

    // Back to ones with non-BCD code: dash after dead time.
    run2(1, 1'b0, 4'd12, 4'b0001, OFF_S, OFF_A, 7'h40, A10, "dash_capture");
    run(4, 1'b0, 4'd12, 4'b0001, OFF_S, OFF_A, "dash_blank");
    run(2, 1'b0, 4'd12, 4'b0001, 7'h3F, A1, "show_dash");

    // Digit 7 -> 8 with anode held: no blank cycle in between.
    run(1, 1'b0, 4'd7, 4'b0001, 7'h3F, A1, "d7_capture");
    run(1, 1'b0, 4'd7, 4'b0001, 7'h78, A1, "show_7");
    run(1, 1'b0, 4'd8, 4'b0001, 7'h78, A1, "d8_capture");
    run(1, 1'b0, 4'd8, 4'b0001, 7'h00, A1, "show_8");

    // Anode change, then another change captured on the 2nd blank cycle:
    // the dead time restarts from the second change.
    run(1, 1'b0, 4'd4, 4'b0010, 7'h00, A1, "retrig_capture1");
    run(1, 1'b0, 4'd4, 4'b0010, OFF_S, OFF_A, "retrig_blank1");
    run(5, 1'b0, 4'd6, 4'b0001, OFF_S, OFF_A, "retrig_blank2");
    run(1, 1'b0, 4'd6, 4'b0001, 7'h02, A1, "show_6");

    // Non-one-hot anode select: everything off even in SHOW.
    run(1, 1'b0, 4'd9, 4'b0011, 7'h02, A1, "bad_an_capture");
    run(7, 1'b0, 4'd9, 4'b0011, OFF_S, OFF_A, "bad_an_off");
    run(5, 1'b0, 4'd9, 4'b0001, OFF_S, OFF_A, "recover_blank");
    run(1, 1'b0, 4'd9, 4'b0001, 7'h10, A1, "show_9");

    // Reset mid-SHOW: off at the same edge, full dead time afterwards.
    run(1, 1'b1, 4'd9, 4'b0001, OFF_S, OFF_A, "reset_mid_show");
    run(5, 1'b0, 4'd9, 4'b0001, OFF_S, OFF_A, "reset_blank");
    run(1, 1'b0, 4'd9, 4'b0001, 7'h10, A1, "show_9_again");

    // Change to tens, then a second change captured as the counter reaches
    // zero: the change wins and blanking restarts.
    run(1, 1'b0, 4'd2, 4'b0010, 7'h10, A1, "race_capture1");
    run(3, 1'b0, 4'd2, 4'b0010, OFF_S, OFF_A, "race_blank1");
    run(5, 1'b0, 4'd5, 4'b0001, OFF_S, OFF_A, "race_blank2");
    run(1, 1'b0, 4'd5, 4'b0001, 7'h12, A1, "show_5_final");

    @(posedge clk);
    #2;
    n_cmp++;
    if (q0.size() != 0 || q1.size() != 0) begin
      n_err++;
      $display("FAIL drain: pending=%0d/%0d expected 0/0", q0.size(), q1.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  // Safety bound on total run time.
  initial begin
    #100000;
    $display("FAIL timeout: time=%0t expected completion", $time);
    $fatal(1, "timeout");
  end

endmodule
